// File: rtl/load_store_bank.sv
// load_store_bank: CH independent fill/dwell/drain volume channels,
// each counting completed round trips.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   [CH]           per-channel advance enable
//   vol       out  [CH*CBITS]     channel i volume at [i*CBITS +: CBITS]
//   filling   out  [CH]           channel in FILL
//   sig       out  [CH]           channel volume == N
//   empty     out  [CH]           channel volume == 0
//   cycles    out  [CH*CYC_BITS]  round trips per channel (wrapping)
//   any_full  out  1              OR of sig
module load_store_bank #(
   parameter int CH       = 4,
   parameter int CBITS    = 14,
   parameter int N        = 12500,
   parameter int STEP     = 1,
   parameter int DWELL    = 0,
   parameter int CYC_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH-1:0]            en,
   output logic [CH*CBITS-1:0]      vol,
   output logic [CH-1:0]            filling,
   output logic [CH-1:0]            sig,
   output logic [CH-1:0]            empty,
   output logic [CH*CYC_BITS-1:0]   cycles,
   output logic                     any_full
);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_DWELL = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [CBITS-1:0] N_C    = CBITS'(N);
   localparam logic [CBITS-1:0] STEP_C = CBITS'(STEP);
   localparam logic [DW-1:0]    DLAST  = DW'(DWELL - 1);
   localparam bit               HAS_DW = (DWELL > 0);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_e                state_q, state_d;
      logic [CBITS-1:0]      vol_q, vol_d;
      logic [DW-1:0]         dcnt_q, dcnt_d;
      logic                  reached_q, reached_d;
      logic [CYC_BITS-1:0]   cyc_q, cyc_d;
      logic                  sig_q, empty_q, fill_q;
      // one extra bit so vol+STEP cannot wrap before the clamp
      logic [CBITS:0]        sum;

      always_comb begin
         state_d   = state_q;
         vol_d     = vol_q;
         dcnt_d    = dcnt_q;
         reached_d = reached_q;
         cyc_d     = cyc_q;
         sum       = {1'b0, vol_q} + {1'b0, STEP_C};
         if (en[i]) begin
            unique case (state_q)
               S_FILL: begin
                  if (vol_q >= N_C) begin
                     reached_d = 1'b1;
                     state_d   = HAS_DW ? S_DWELL : S_DRAIN;
                  end else if (sum >= {1'b0, N_C}) begin
                     vol_d = N_C;
                  end else begin
                     vol_d = sum[CBITS-1:0];
                  end
               end
               S_DWELL: begin
                  if (dcnt_q == DLAST) begin
                     dcnt_d  = '0;
                     state_d = S_DRAIN;
                  end else begin
                     dcnt_d = dcnt_q + 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (vol_q == '0) begin
                     state_d = S_FILL;
                     // first exit after reset has no prior fill to count
                     if (reached_q) begin
                        cyc_d     = cyc_q + 1'b1;
                        reached_d = 1'b0;
                     end
                  end else if (vol_q >= STEP_C) begin
                     vol_d = vol_q - STEP_C;
                  end else begin
                     vol_d = '0;
                  end
               end
               default: state_d = S_DRAIN;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q   <= S_DRAIN;
            vol_q     <= '0;
            dcnt_q    <= '0;
            reached_q <= 1'b0;
            cyc_q     <= '0;
            sig_q     <= 1'b0;
            empty_q   <= 1'b1;
            fill_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            vol_q     <= vol_d;
            dcnt_q    <= dcnt_d;
            reached_q <= reached_d;
            cyc_q     <= cyc_d;
            // flags registered from post-update state
            sig_q     <= (vol_d == N_C);
            empty_q   <= (vol_d == '0);
            fill_q    <= (state_d == S_FILL);
         end
      end

      assign vol[i*CBITS +: CBITS]          = vol_q;
      assign cycles[i*CYC_BITS +: CYC_BITS] = cyc_q;
      assign sig[i]                         = sig_q;
      assign empty[i]                       = empty_q;
      assign filling[i]                     = fill_q;
   end

   assign any_full = |sig;

endmodule

// File: tb/tb_load_store_bank.sv
// tb_load_store_bank: scoreboard bench for load_store_bank.
// DUT A: 1 ch, N=10, STEP=1; DUT B: 2 ch, N=10, STEP=3, DWELL=2.
module tb_load_store_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: reference profile, mid-run reset, cycle counter wrap
   logic        rstA;
   logic [0:0]  enA;
   logic [3:0]  volA;
   logic [0:0]  filA, sigA, empA;
   logic [1:0]  cycA;
   logic        anyA;

   load_store_bank #(
      .CH(1), .CBITS(4), .N(10), .STEP(1), .DWELL(0), .CYC_BITS(2)
   ) u_a (
      .clk(clk), .rst(rstA), .en(enA),
      .vol(volA), .filling(filA), .sig(sigA), .empty(empA),
      .cycles(cycA), .any_full(anyA)
   );

   // DUT B: saturating step, dwell, per-channel stall
   logic        rstB;
   logic [1:0]  enB;
   logic [9:0]  volB;
   logic [1:0]  filB, sigB, empB;
   logic [15:0] cycB;
   logic        anyB;

   load_store_bank #(
      .CH(2), .CBITS(5), .N(10), .STEP(3), .DWELL(2), .CYC_BITS(8)
   ) u_b (
      .clk(clk), .rst(rstB), .en(enB),
      .vol(volB), .filling(filB), .sig(sigB), .empty(empB),
      .cycles(cycB), .any_full(anyB)
   );

   typedef struct {
      int dut;
      int k;
      int v0;
      int v1;
      int f0;
      int f1;
      int c0;
      int c1;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   // Hand-derived channel traces for DUT B, cycles 1..20 (index 0 unused).
   // ch1 is stalled on cycles 3..7 (mid-FILL) and 13..14 (mid-DWELL).
   int bv0[21] = '{0, 0,3,6,9,10,10,10,10,7,4,1,0,0,3,6,9,10,10,10,10};
   int bf0[21] = '{0, 1,1,1,1,1, 0,0,0,0,0,0,0, 1,1,1,1,1, 0,0,0};
   int bc0[21] = '{0, 0,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1};
   int bv1[21] = '{0, 0,3,3,3,3,3,3,6,9,10,10,10,10,10,10,7,4,1,0,0};
   int bf1[21] = '{0, 1,1,1,1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0, 1};
   int bc1[21] = '{0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1};

   task automatic chk(input string nm, input int k,
                      input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_mis++;
         $display("FAIL %s cycle %0d: got %0d, required %0d",
                  nm, k, act, req);
      end
   endtask

   // Reference profile (STEP=1, DWELL=0, N=10): period 2N+2=22.
   function automatic exp_t prof(input int k);
      exp_t e;
      int   p;
      p    = (k - 1) % 22;
      e.dut = 0;
      e.k  = k;
      e.v0 = (p <= 10) ? p : 21 - p;
      e.f0 = (p <= 10) ? 1 : 0;
      e.c0 = ((k - 1) / 22) % 4;
      e.v1 = 0;
      e.f1 = 0;
      e.c1 = 0;
      return e;
   endfunction

   function automatic exp_t rst_exp(input int d);
      exp_t e;
      e.dut = d;
      e.k  = 0;
      e.v0 = 0;
      e.v1 = 0;
      e.f0 = 0;
      e.f1 = 0;
      e.c0 = 0;
      e.c1 = 0;
      return e;
   endfunction

   // Monitor: checks whatever expectation was queued for the last edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
               chk("A_vol",   e.k, int'(volA), e.v0);
               chk("A_fill",  e.k, int'(filA), e.f0);
               chk("A_sig",   e.k, int'(sigA), int'(e.v0 == 10));
               chk("A_empty", e.k, int'(empA), int'(e.v0 == 0));
               chk("A_cyc",   e.k, int'(cycA), e.c0);
               chk("A_any",   e.k, int'(anyA), int'(e.v0 == 10));
            end else begin
               chk("B0_vol",   e.k, int'(volB[4:0]), e.v0);
               chk("B1_vol",   e.k, int'(volB[9:5]), e.v1);
               chk("B0_fill",  e.k, int'(filB[0]), e.f0);
               chk("B1_fill",  e.k, int'(filB[1]), e.f1);
               chk("B0_sig",   e.k, int'(sigB[0]), int'(e.v0 == 10));
               chk("B1_sig",   e.k, int'(sigB[1]), int'(e.v1 == 10));
               chk("B0_empty", e.k, int'(empB[0]), int'(e.v0 == 0));
               chk("B1_empty", e.k, int'(empB[1]), int'(e.v1 == 0));
               chk("B0_cyc",   e.k, int'(cycB[7:0]), e.c0);
               chk("B1_cyc",   e.k, int'(cycB[15:8]), e.c1);
               chk("B_any",    e.k, int'(anyB),
                   int'((e.v0 == 10) || (e.v1 == 10)));
            end
         end
      end
   end

   // Stimulus: sets inputs on the falling edge and queues the
   // expected outputs after the next rising edge.
   initial begin
      exp_t e;
      int   w;
      rstA = 1'b1;
      rstB = 1'b1;
      enA  = 1'b1;
      enB  = 2'b11;
      repeat (2) @(posedge clk);

      // DUT B
      @(negedge clk);
      rstB = 1'b1;
      q.push_back(rst_exp(1));
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         rstB   = 1'b0;
         enB[0] = 1'b1;
         enB[1] = ((k >= 3 && k <= 7) || (k >= 13 && k <= 14))
                  ? 1'b0 : 1'b1;
         e.dut = 1;
         e.k  = k;
         e.v0 = bv0[k];
         e.v1 = bv1[k];
         e.f0 = bf0[k];
         e.f1 = bf1[k];
         e.c0 = bc0[k];
         e.c1 = bc1[k];
         q.push_back(e);
      end
      @(negedge clk);
      rstB = 1'b1;
      enB  = 2'b11;

      // DUT A: reset state, then profile until vol=7 in DRAIN, cycles=3
      rstA = 1'b1;
      q.push_back(rst_exp(0));
      for (int k = 1; k <= 81; k++) begin
         @(negedge clk);
         rstA = 1'b0;
         q.push_back(prof(k));
      end
      // one-cycle reset with en still high
      @(negedge clk);
      rstA = 1'b1;
      q.push_back(rst_exp(0));
      // restart: first FILL entry must not count; then wrap 0..3,0,1
      for (int k = 1; k <= 115; k++) begin
         @(negedge clk);
         rstA = 1'b0;
         q.push_back(prof(k));
      end

      w = 0;
      while (q.size() > 0 && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (q.size() > 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL drain: %0d expectations left, required 0",
                  q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end

endmodule
